mining_job_loader: RTL
======================

MINING_JOB_LOADER -- requirements
Module: mining_job_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the WAIT-state cycle limit, used only when JOB_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port byte_in  input  8  job byte stream data.
REQ-005 SHALL have port byte_valid  input  1  byte_in carries a byte.
REQ-006 SHALL have port byte_ready  output  1  loader accepts byte_in this cycle.
REQ-007 SHALL have port target  output  8  target to the nonce-search system.
REQ-008 SHALL have port block  output  96  block to the nonce-search system.
REQ-009 SHALL have port start  output  1  start pulse to the nonce-search system.
REQ-010 SHALL have port sys_rst  output  1  soft reset to the nonce-search system (ORed with reset at top level).
REQ-011 SHALL have port terminado  input  1  done flag from the nonce-search system.
REQ-012 SHALL have port nonce  input  32  nonce from the nonce-search system.
REQ-013 SHALL have port result_nonce  output  32  captured nonce.
REQ-014 SHALL have port result_valid  output  1  result_nonce valid.
REQ-015 SHALL have port result_ready  input  1  consumer accepts the result.
REQ-016 SHALL have port result_timeout  output  1  result is a timeout, not a found nonce; tied 0 without JOB_TIMEOUT_EN.

Function
REQ-017 SHALL implement the one-hot FSM LOAD, ISSUE, WAIT, REPORT, RECOVER.
REQ-018 SHALL drive byte_ready=1 only in LOAD; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-019 SHALL treat a job frame as 13 bytes: byte 0 is target, bytes 1..12 fill block MSB-first (byte 1 -> block[95:88], byte 12 -> block[7:0]).
REQ-020 SHALL count accepted bytes 0..12; acceptance of byte 12 moves LOAD->ISSUE and clears the count.
REQ-021 SHALL hold target and block stable from ISSUE until re-entry to LOAD.
REQ-022 SHALL assert start for exactly one cycle, the ISSUE cycle, then move to WAIT.
REQ-023 In WAIT, SHALL capture nonce into result_nonce on the first cycle terminado=1 and move to REPORT.
REQ-024 SHALL hold result_valid=1 throughout REPORT; result_ready=1 moves to RECOVER; result_nonce and result_timeout SHALL remain stable while result_valid=1.
REQ-025 SHALL assert sys_rst for exactly one cycle, the RECOVER cycle, then return to LOAD.
REQ-026 SHALL ignore terminado outside WAIT and ignore byte_valid outside LOAD.
REQ-027 Total latency from the 13th byte accept to start=1 SHALL be 1 cycle; from terminado=1 to result_valid=1 SHALL be 1 cycle.

Reset
REQ-028 On reset=1, SHALL immediately enter LOAD with count=0, target=0, block=0, start=0, sys_rst=0, result_nonce=0, result_valid=0, result_timeout=0, byte_ready=0 until the first clock after reset release.
REQ-029 Reset mid-frame or mid-job SHALL discard partial bytes and any pending result.

Configuration
REQ-030 With JOB_TIMEOUT_EN defined, SHALL count WAIT cycles; reaching TIMEOUT_CYCLES without terminado SHALL move to REPORT with result_timeout=1 and result_nonce=0.
REQ-031 If terminado=1 on the same cycle the limit is reached, the nonce result SHALL win (result_timeout=0).
REQ-032 Without JOB_TIMEOUT_EN, SHALL have no timeout counter, wait in WAIT indefinitely, and tie result_timeout to 0.

Structure
REQ-033 SHALL take the state encodings, FRAME_BYTES=13 and the byte-index width from a shared package mining_pkg.
REQ-034 SHALL place byte assembly (count, target, block registers) in the sub-module job_frame_assembler; the FSM, result capture and timeout stay in the top.

Verification
REQ-035 Test 1: stream 13 bytes 0x10,0x00..0x0B back-to-back -> start pulses 1 cycle later with target=0x10, block=0x000102030405060708090A0B.
REQ-036 Test 2: bytes with random byte_valid gaps -> identical target and block to Test 1, and byte_ready=0 in every non-LOAD state.
REQ-037 Test 3: terminado=1 with nonce=0xDEADBEEF, result_ready held 0 for 5 cycles -> result_valid stays 1 with result_nonce=0xDEADBEEF; after result_ready=1, a single sys_rst pulse follows, then LOAD.
REQ-038 Test 4: reset asserted after 7 bytes -> outputs 0 asynchronously; a fresh 13-byte frame then loads correctly.
REQ-039 Test 5 (JOB_TIMEOUT_EN, TIMEOUT_CYCLES=20): terminado held 0 -> result_valid with result_timeout=1 and result_nonce=0 after 20 WAIT cycles; terminado=1 on cycle 20 -> result_timeout=0.
REQ-040 Test 6: terminado=1 during LOAD -> no state change and no result.

Source files
------------

// File: rtl/mining_pkg.sv
// Shared types and constants for the mining job loader: FSM encoding, frame size, byte index.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mining_pkg;

   localparam int FRAME_BYTES = 13;
   localparam int IDX_W       = $clog2(FRAME_BYTES);
   localparam int BLOCK_W     = 96;

   typedef logic [IDX_W-1:0] byte_idx_t;

   localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_BYTES - 1);

   // One-hot job controller states.
   typedef enum logic [4:0] {
      ST_LOAD    = 5'b00001,
      ST_ISSUE   = 5'b00010,
      ST_WAIT    = 5'b00100,
      ST_REPORT  = 5'b01000,
      ST_RECOVER = 5'b10000
   } state_e;

endpackage

// File: rtl/job_frame_assembler.sv
// Assembles a 13-byte job frame: byte 0 -> target, bytes 1..12 -> block MSB-first.
// Latency: frame_done_o is combinational on the accept of the last byte; registers update next edge.
// Backpressure: none here; the parent gates acc_i with its own ready.
module job_frame_assembler
   import mining_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         byte_i,
   input  logic               acc_i,
   output logic [7:0]         target_o,
   output logic [BLOCK_W-1:0] block_o,
   output logic               frame_done_o
);

   byte_idx_t          cnt_q, cnt_d;
   logic [7:0]         target_q, target_d;
   logic [BLOCK_W-1:0] block_q, block_d;

   // Next-state: route each accepted byte by its index; block shifts in from the LSB so byte 1 lands on top.
   always_comb begin
      cnt_d    = cnt_q;
      target_d = target_q;
      block_d  = block_q;
      if (acc_i) begin
         if (cnt_q == '0) begin
            target_d = byte_i;
         end else begin
            block_d = {block_q[BLOCK_W-9:0], byte_i};
         end
         if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + byte_idx_t'(1);
         end
      end
   end

   // Frame registers; reset discards any partial frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         target_q <= '0;
         block_q  <= '0;
      end else begin
         cnt_q    <= cnt_d;
         target_q <= target_d;
         block_q  <= block_d;
      end
   end

   assign target_o     = target_q;
   assign block_o      = block_q;
   assign frame_done_o = acc_i && (cnt_q == LAST_IDX);

endmodule

// File: rtl/mining_job_loader.sv
// Loads a job frame, starts the nonce search, captures/holds its result, then soft-resets it. Optional macro: JOB_TIMEOUT_EN.
// Latency: last byte accept -> start 1 cycle; terminado -> result_valid 1 cycle.
// Backpressure: byte_ready only in LOAD; result held in REPORT until result_ready.
module mining_job_loader
   import mining_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65535
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic [7:0]         target,
   output logic [BLOCK_W-1:0] block,
   output logic               start,
   output logic               sys_rst,
   input  logic               terminado,
   input  logic [31:0]        nonce,
   output logic [31:0]        result_nonce,
   output logic               result_valid,
   input  logic               result_ready,
   output logic               result_timeout
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e      state_q, state_d;
   logic [31:0] res_nonce_q, res_nonce_d;
   logic        rdy_en_q;
   logic        byte_acc;
   logic        frame_done;

`ifdef JOB_TIMEOUT_EN
   logic [31:0] wait_cnt_q, wait_cnt_d;
   logic        res_tmo_q, res_tmo_d;
`endif

   // rdy_en_q keeps byte_ready low between reset release and the first clock.
   assign byte_ready   = (state_q == ST_LOAD) && rdy_en_q;
   assign byte_acc     = byte_valid && byte_ready;
   assign start        = (state_q == ST_ISSUE);
   assign result_valid = (state_q == ST_REPORT);
   assign sys_rst      = (state_q == ST_RECOVER);
   assign result_nonce = res_nonce_q;

`ifdef JOB_TIMEOUT_EN
   assign result_timeout = res_tmo_q;
`else
   assign result_timeout = 1'b0;
`endif

   job_frame_assembler u_asm (
      .clk          (clk),
      .reset        (reset),
      .byte_i       (byte_in),
      .acc_i        (byte_acc),
      .target_o     (target),
      .block_o      (block),
      .frame_done_o (frame_done)
   );

   // Next-state and result capture; a found nonce beats a timeout landing on the same cycle.
   always_comb begin
      state_d     = state_q;
      res_nonce_d = res_nonce_q;
`ifdef JOB_TIMEOUT_EN
      res_tmo_d   = res_tmo_q;
      wait_cnt_d  = '0;
`endif
      case (state_q)
         ST_LOAD: begin
            if (frame_done) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (terminado) begin
               res_nonce_d = nonce;
`ifdef JOB_TIMEOUT_EN
               res_tmo_d   = 1'b0;
`endif
               state_d     = ST_REPORT;
            end
`ifdef JOB_TIMEOUT_EN
            else if (wait_cnt_q == TIMEOUT_CYCLES - 1) begin
               res_nonce_d = '0;
               res_tmo_d   = 1'b1;
               state_d     = ST_REPORT;
            end else begin
               wait_cnt_d = wait_cnt_q + 32'd1;
            end
`endif
         end
         ST_REPORT: begin
            if (result_ready) state_d = ST_RECOVER;
         end
         ST_RECOVER: begin
            state_d = ST_LOAD;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // State and result registers; reset drops any pending result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_LOAD;
         res_nonce_q <= '0;
         rdy_en_q    <= 1'b0;
`ifdef JOB_TIMEOUT_EN
         res_tmo_q   <= 1'b0;
         wait_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         res_nonce_q <= res_nonce_d;
         rdy_en_q    <= 1'b1;
`ifdef JOB_TIMEOUT_EN
         res_tmo_q   <= res_tmo_d;
         wait_cnt_q  <= wait_cnt_d;
`endif
      end
   end

endmodule
